// File: rtl/ether_fcs_append.sv
`timescale 1ns/1ps
// Purpose: passes an RMII dibit frame through and appends the Ethernet CRC-32 FCS, then holds the inter-frame gap.
// Latency: 1 cycle in to out; the FCS directly follows the payload with no gap, then 48 idle cycles.
// Backpressure: none on the data path; busy (PAD/FCS/IFG) tells upstream not to start a frame.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   axiiv, axiid   input dibit valid / dibit (axiid[0] is earlier on the wire)
//   axiov, axiod   output dibit valid / dibit (axiod is 2'b00 whenever axiov is low)
//   busy           high in PAD, FCS or IFG
//   err            one-cycle pulse on a runt frame or on a frame start while busy
// Optional feature: define ETHER_FCS_PAD_EN to pad short payloads to 60 bytes before the FCS.
module ether_fcs_append (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       busy,
    output logic       err
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [4:0]  PRE_LAST = 5'd31;
    localparam logic [5:0]  IFG_LAST = 6'd47;
    localparam logic [12:0] CNT_MAX  = 13'h1FFF;
`ifdef ETHER_FCS_PAD_EN
    localparam logic [12:0] MIN_DIBITS = 13'd240;
`endif

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        FCS,
        IFG
`ifdef ETHER_FCS_PAD_EN
        , PAD
`endif
    } state_t;

    // Reflected CRC-32, two bits per call, d[0] shifted in first.
    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    state_t      state;
    logic [31:0] crc;
    logic [4:0]  pre_cnt;
    logic [12:0] data_cnt;
    logic [3:0]  fcs_cnt;
    logic [5:0]  ifg_cnt;
    logic        armed;
    logic        start_ok;

    // armed records that axiiv was low last cycle, so axiiv && armed is a rising
    // edge. A rise that is refused leaves armed low until axiiv drops again.
    assign start_ok = axiiv && armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            crc      <= CRC_INIT;
            pre_cnt  <= '0;
            data_cnt <= '0;
            fcs_cnt  <= '0;
            ifg_cnt  <= '0;
            armed    <= 1'b0;
            axiov    <= 1'b0;
            axiod    <= 2'b00;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            armed <= !axiiv;
            axiov <= 1'b0;
            axiod <= 2'b00;
            err   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        axiov    <= 1'b1;
                        axiod    <= axiid;
                        pre_cnt  <= 5'd1;
                        data_cnt <= '0;
                        crc      <= CRC_INIT;
                        state    <= PRE;
                    end
                end

                PRE: begin
                    if (axiiv) begin
                        axiov   <= 1'b1;
                        axiod   <= axiid;
                        pre_cnt <= pre_cnt + 5'd1;
                        if (pre_cnt == PRE_LAST) begin
                            state <= DATA;
                        end
                    end else begin
                        // Runt: the cycle that saw axiiv low already counts as the
                        // first idle cycle on the wire, so the gap starts at 1.
                        err     <= 1'b1;
                        busy    <= 1'b1;
                        ifg_cnt <= 6'd1;
                        state   <= IFG;
                    end
                end

                DATA: begin
                    if (axiiv) begin
                        axiov <= 1'b1;
                        axiod <= axiid;
                        crc   <= crc_dibit(crc, axiid);
                        if (data_cnt != CNT_MAX) begin
                            data_cnt <= data_cnt + 13'd1;
                        end
                    end else begin
                        // End of payload: emit the first pad/FCS dibit this cycle
                        // so axiov has no hole after the last data dibit.
                        busy  <= 1'b1;
                        axiov <= 1'b1;
`ifdef ETHER_FCS_PAD_EN
                        if (data_cnt < MIN_DIBITS) begin
                            axiod    <= 2'b00;
                            crc      <= crc_dibit(crc, 2'b00);
                            data_cnt <= data_cnt + 13'd1;
                            fcs_cnt  <= 4'd0;
                            state    <= (data_cnt == MIN_DIBITS - 13'd1) ? FCS : PAD;
                        end else begin
                            axiod   <= ~crc[1:0];
                            fcs_cnt <= 4'd1;
                            state   <= FCS;
                        end
`else
                        axiod   <= ~crc[1:0];
                        fcs_cnt <= 4'd1;
                        state   <= FCS;
`endif
                    end
                end

`ifdef ETHER_FCS_PAD_EN
                PAD: begin
                    axiov    <= 1'b1;
                    axiod    <= 2'b00;
                    crc      <= crc_dibit(crc, 2'b00);
                    data_cnt <= data_cnt + 13'd1;
                    if (data_cnt == MIN_DIBITS - 13'd1) begin
                        fcs_cnt <= 4'd0;
                        state   <= FCS;
                    end
                end
`endif

                FCS: begin
                    axiov <= 1'b1;
                    axiod <= ~crc[{fcs_cnt, 1'b0} +: 2];
                    if (fcs_cnt == 4'd15) begin
                        ifg_cnt <= 6'd0;
                        state   <= IFG;
                    end else begin
                        fcs_cnt <= fcs_cnt + 4'd1;
                    end
                end

                IFG: begin
                    if (ifg_cnt == IFG_LAST) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt + 6'd1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // A frame start while busy is dropped; only the error is reported.
            if (busy && start_ok) begin
                err <= 1'b1;
            end
        end
    end

endmodule
